// File: rtl/rf_loader.sv
// rf_loader: streams a block of words into consecutive register-file entries.
// A start in IDLE latches a base index and a word count; each accepted beat
// produces a registered write one cycle later. The index wraps from 31 to 0.
// busy stays high for the whole load so CPU-side writes can be held off.
module rf_loader #(
   parameter bit ZERO_PROTECT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  base_reg,
   input  logic [5:0]  count,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic [4:0]  writereg,
   output logic [31:0] writedata,
   output logic        write,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  ptr_q, ptr_d;
   logic [5:0]  rem_q, rem_d;
   logic        write_q, write_d;
   logic [4:0]  writereg_q, writereg_d;
   logic [31:0] writedata_q, writedata_d;
   logic        err_q, err_d;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Datapath registers: pointer, remaining count and the registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         rem_q       <= '0;
         write_q     <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         write_q     <= write_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
         err_q       <= err_d;
      end
   end

   // Next-state and datapath update; write index/data hold unless a real write occurs.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      write_d     = 1'b0;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (count == 6'd0) begin
                  state_d = StDone;
               end else if (count > 6'd32) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StLoad;
                  ptr_d   = base_reg;
                  rem_d   = count;
               end
            end
         end
         StLoad: begin
            if (in_valid) begin
               ptr_d = ptr_q + 5'd1;
               rem_d = rem_q - 6'd1;
               // Beats aimed at register 0 are swallowed when protection is on.
               if (!(ZERO_PROTECT && ptr_q == 5'd0)) begin
                  write_d     = 1'b1;
                  writereg_d  = ptr_q;
                  writedata_d = in_data;
               end
               if (rem_q == 6'd1) state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from state or taken straight from registers.
   always_comb begin
      in_ready  = (state_q == StLoad);
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      write     = write_q;
      writereg  = writereg_q;
      writedata = writedata_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_rf_loader.sv
// Self-checking bench for rf_loader: expected register writes are queued as
// beats are driven and checked when the DUT raises write.
module tb_rf_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  base_reg;
   logic [5:0]  count;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic        write;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;

   rf_loader #(.ZERO_PROTECT(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_reg  (base_reg),
      .count     (count),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .writereg  (writereg),
      .writedata (writedata),
      .write     (write),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (write === 1'b1) begin
         if (sb.size() == 0) begin
            check("write_expected", 32'(sb.size()), 32'd1);
         end else begin
            mon_e = sb.pop_front();
            check("writereg", 32'(writereg), 32'(mon_e.r));
            check("writedata", writedata, mon_e.d);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_write"}, 32'(write), 32'd0);
      check({tag, "_writereg"}, 32'(writereg), 32'd0);
      check({tag, "_writedata"}, writedata, 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Drive one load. vpat gives in_valid per cycle (or random if vrand);
   // dstep==0 means random data. abort_after>=0 asserts rst after that many beats.
   task automatic do_load(input logic [4:0] base, input logic [5:0] cnt,
                          input logic [63:0] vpat, input bit vrand,
                          input logic [31:0] dbase, input logic [31:0] dstep,
                          input bit hold_start, input int abort_after);
      logic [4:0]  p = base;
      logic [31:0] d;
      int          beats = 0;
      bit          last_wr = 1'b0;
      bit          v;
      d = (dstep == 0) ? $urandom : dbase;
      @(posedge clk); #1;
      start = 1'b1; base_reg = base; count = cnt;
      @(posedge clk); #1;
      // A start held during LOAD must be ignored: no relatch, no err.
      start = hold_start; base_reg = ~base; count = hold_start ? 6'd40 : cnt;
      check("busy_load", 32'(busy), 32'd1);
      check("in_ready_load", 32'(in_ready), 32'd1);
      for (int i = 0; i < 400 && beats < int'(cnt); i++) begin
         if (abort_after >= 0 && beats == abort_after) begin
            rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = d;
            @(posedge clk); #1;
            check_all_zero("abort");
            rst = 1'b0; start = 1'b0; in_valid = 1'b0;
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_sb_drained", 32'(sb.size()), 32'd0);
            return;
         end
         v = vrand ? 1'($urandom_range(0, 1)) : vpat[i % 64];
         in_valid = v;
         in_data  = d;
         if (v) begin
            last_wr = (p != 5'd0);
            if (last_wr) sb.push_back('{r: p, d: d});
            p = p + 5'd1;
            beats++;
            d = (dstep == 0) ? $urandom : d + dstep;
         end
         @(posedge clk); #1;
         if (hold_start) check("err_ignored", 32'(err), 32'd0);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (beats != int'(cnt)) begin
         check("load_timeout", 32'(beats), 32'(cnt));
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         sb.delete();
         return;
      end
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd1);
      check("ready_done", 32'(in_ready), 32'd0);
      check("write_with_done", 32'(write), 32'(last_wr));
      @(posedge clk); #1;
      check("done_clear", 32'(done), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset wins over start and in_valid asserted together.
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = '1;
      base_reg = 5'd5; count = 6'd4;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;

      // Straight load, regs 1..4 with 0xA..0xD.
      do_load(5'd1, 6'd4, '1, 1'b0, 32'hA, 32'd1, 1'b0, -1);
      // Wrap through register 0, which is swallowed.
      do_load(5'd30, 6'd4, '1, 1'b0, 32'h11, 32'h11, 1'b0, -1);
      // Gappy source: valid 1,0,0,1,0,1.
      do_load(5'd5, 6'd3, 64'b101001, 1'b0, 32'h500, 32'd1, 1'b0, -1);

      // count=0: straight to DONE, no write.
      @(posedge clk); #1;
      start = 1'b1; base_reg = 5'd3; count = 6'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd1);
      check("zero_err", 32'(err), 32'd0);
      check("zero_write", 32'(write), 32'd0);
      @(posedge clk); #1;
      check("zero_done_clear", 32'(done), 32'd0);
      check("zero_busy_clear", 32'(busy), 32'd0);

      // count=40: rejected with a one-cycle err.
      start = 1'b1; base_reg = 5'd3; count = 6'd40;
      @(posedge clk); #1;
      start = 1'b0;
      check("reject_err", 32'(err), 32'd1);
      check("reject_busy", 32'(busy), 32'd0);
      check("reject_ready", 32'(in_ready), 32'd0);
      check("reject_write", 32'(write), 32'd0);
      @(posedge clk); #1;
      check("reject_err_clear", 32'(err), 32'd0);
      check("reject_busy_clear", 32'(busy), 32'd0);

      // Reset after 3 beats of an 8-word load, then a normal load.
      do_load(5'd10, 6'd8, '1, 1'b0, 32'h100, 32'd1, 1'b0, 3);
      do_load(5'd12, 6'd2, '1, 1'b0, 32'h200, 32'd1, 1'b0, -1);

      // start held high through LOAD is ignored.
      do_load(5'd20, 6'd5, '1, 1'b0, 32'h55, 32'd3, 1'b1, -1);
      // Full 32-word sweep starting at 0.
      do_load(5'd0, 6'd32, '1, 1'b0, 32'h1000, 32'd1, 1'b0, -1);
      // Random base, count, valid pattern and data.
      repeat (4) begin
         do_load(5'($urandom_range(0, 31)), 6'($urandom_range(1, 32)), '0, 1'b1,
                 32'd0, 32'd0, 1'b0, -1);
      end

      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
